// File: rtl/types_pkg.sv
// Shared ROB/PRF sizing, branch checkpoint snapshot layout and recovery FSM states.
package types_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int PRF_SIZE  = 128;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [31:0]          pc;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PRF_SIZE-1:0]  reg_rdy_table;
    logic                 valid;
  } checkpoint;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_WALK     = 3'd2,
    ST_RESTORE  = 3'd3,
    ST_REDIRECT = 3'd4
  } recovery_state_e;

endpackage

// File: rtl/mispredict_recovery.sv
// Branch mispredict recovery sequencer: flush, youngest-first ROB walk-back, PRF/tail restore, redirect.
// Registered outputs; the walk holds walk_tag while walk_ready is low, and mispredicts arriving while busy are dropped.
module mispredict_recovery
  import types_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mispredict,
  input  logic [ROB_TAG_W-1:0] mispredict_tag,
  input  logic [31:0]          mispredict_target,
  input  logic [ROB_TAG_W-1:0] rob_tail,
  input  logic                 checkpoint_valid,
  input  checkpoint            snapshot,
  input  logic                 walk_ready,
  output logic                 walk_valid,
  output logic [ROB_TAG_W-1:0] walk_tag,
  output logic                 flush,
  output logic                 stall_frontend,
  output logic                 rdy_restore_valid,
  output logic [PRF_SIZE-1:0]  rdy_restore,
  output logic                 tail_restore_valid,
  output logic [ROB_TAG_W-1:0] tail_restore,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 busy,
  output logic                 ckpt_miss
);

  recovery_state_e      state_q, state_d;
  logic [ROB_TAG_W-1:0] tag_q, tag_d;
  logic [31:0]          target_q, target_d;
  logic [PRF_SIZE-1:0]  table_q, table_d;
  logic                 miss_q, miss_d;
  logic                 no_walk_q, no_walk_d;
  logic [ROB_TAG_W-1:0] walk_tag_q, walk_tag_d;
  logic [ROB_TAG_W-1:0] walk_cnt;
  logic [ROB_TAG_W-1:0] restore_tail;

  logic                 flush_q, ckpt_miss_q, walk_valid_q, busy_q;
  logic                 rdy_restore_valid_q, tail_restore_valid_q, redirect_valid_q;
  logic [PRF_SIZE-1:0]  rdy_restore_q;
  logic [ROB_TAG_W-1:0] tail_restore_q;
  logic [31:0]          redirect_pc_q;

  // Only the ready table is consumed; the other snapshot fields are owned by the checkpoint store.
  logic unused_snapshot;
  assign unused_snapshot = ^{snapshot.pc, snapshot.rob_tag, snapshot.valid};

  assign walk_cnt     = rob_tail - mispredict_tag - 5'd1;
  assign restore_tail = tag_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    target_d   = target_q;
    table_d    = table_q;
    miss_d     = miss_q;
    no_walk_d  = no_walk_q;
    walk_tag_d = walk_tag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d    = ST_FLUSH;
          tag_d      = mispredict_tag;
          target_d   = mispredict_target;
          table_d    = snapshot.reg_rdy_table;
          miss_d     = !checkpoint_valid;
          no_walk_d  = (walk_cnt == '0);
          walk_tag_d = rob_tail - 5'd1;
        end
      end
      ST_FLUSH:    state_d = no_walk_q ? ST_RESTORE : ST_WALK;
      ST_WALK: begin
        // The entry just above the branch is the last one squashed.
        if (walk_valid_q && walk_ready) begin
          if (walk_tag_q == restore_tail) state_d    = ST_RESTORE;
          else                            walk_tag_d = walk_tag_q - 5'd1;
        end
      end
      ST_RESTORE:  state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= ST_IDLE;
      tag_q                <= '0;
      target_q             <= '0;
      table_q              <= '0;
      miss_q               <= 1'b0;
      no_walk_q            <= 1'b0;
      walk_tag_q           <= '0;
      flush_q              <= 1'b0;
      ckpt_miss_q          <= 1'b0;
      walk_valid_q         <= 1'b0;
      busy_q               <= 1'b0;
      rdy_restore_valid_q  <= 1'b0;
      rdy_restore_q        <= '0;
      tail_restore_valid_q <= 1'b0;
      tail_restore_q       <= '0;
      redirect_valid_q     <= 1'b0;
      redirect_pc_q        <= '0;
    end else begin
      state_q              <= state_d;
      tag_q                <= tag_d;
      target_q             <= target_d;
      table_q              <= table_d;
      miss_q               <= miss_d;
      no_walk_q            <= no_walk_d;
      walk_tag_q           <= walk_tag_d;
      flush_q              <= (state_d == ST_FLUSH);
      ckpt_miss_q          <= (state_d == ST_FLUSH) && miss_d;
      walk_valid_q         <= (state_d == ST_WALK);
      busy_q               <= (state_d != ST_IDLE);
      rdy_restore_valid_q  <= (state_d == ST_RESTORE) && !miss_q;
      rdy_restore_q        <= (state_d == ST_RESTORE) ? table_q : '0;
      tail_restore_valid_q <= (state_d == ST_RESTORE);
      tail_restore_q       <= (state_d == ST_RESTORE) ? restore_tail : '0;
      redirect_valid_q     <= (state_d == ST_REDIRECT);
      redirect_pc_q        <= (state_d == ST_REDIRECT) ? target_q : '0;
    end
  end

  assign walk_valid         = walk_valid_q;
  assign walk_tag           = walk_tag_q;
  assign flush              = flush_q;
  assign stall_frontend     = busy_q;
  assign busy               = busy_q;
  assign ckpt_miss          = ckpt_miss_q;
  assign rdy_restore_valid  = rdy_restore_valid_q;
  assign rdy_restore        = rdy_restore_q;
  assign tail_restore_valid = tail_restore_valid_q;
  assign tail_restore       = tail_restore_q;
  assign redirect_valid     = redirect_valid_q;
  assign redirect_pc        = redirect_pc_q;

endmodule

// File: tb/tb_mispredict_recovery.sv
// Scoreboard bench: directed mispredicts push hand-computed output events; a negedge monitor pops and compares.
module tb_mispredict_recovery;
  import types_pkg::*;

  logic         clk;
  logic         reset;
  logic         mispredict;
  logic [4:0]   mispredict_tag;
  logic [31:0]  mispredict_target;
  logic [4:0]   rob_tail;
  logic         checkpoint_valid;
  checkpoint    snapshot;
  logic         walk_ready;
  logic         walk_valid;
  logic [4:0]   walk_tag;
  logic         flush;
  logic         stall_frontend;
  logic         rdy_restore_valid;
  logic [127:0] rdy_restore;
  logic         tail_restore_valid;
  logic [4:0]   tail_restore;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         busy;
  logic         ckpt_miss;

  mispredict_recovery dut (
    .clk                (clk),
    .reset              (reset),
    .mispredict         (mispredict),
    .mispredict_tag     (mispredict_tag),
    .mispredict_target  (mispredict_target),
    .rob_tail           (rob_tail),
    .checkpoint_valid   (checkpoint_valid),
    .snapshot           (snapshot),
    .walk_ready         (walk_ready),
    .walk_valid         (walk_valid),
    .walk_tag           (walk_tag),
    .flush              (flush),
    .stall_frontend     (stall_frontend),
    .rdy_restore_valid  (rdy_restore_valid),
    .rdy_restore        (rdy_restore),
    .tail_restore_valid (tail_restore_valid),
    .tail_restore       (tail_restore),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .busy               (busy),
    .ckpt_miss          (ckpt_miss)
  );

  localparam logic [127:0] TBL_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] TBL_B = 128'hFFFF_0000_AAAA_5555_0F0F_F0F0_1234_5678;
  localparam logic [127:0] TBL_C = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] TBL_D = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  typedef enum int {EV_FLUSH, EV_MISS, EV_WALK, EV_RDY, EV_TAIL, EV_REDIR} ev_kind_e;
  typedef struct {
    ev_kind_e     kind;
    int           cyc;
    logic [127:0] dat;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  edge_cnt = 0;
  int  t;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt = edge_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input ev_kind_e k, input int c, input logic [127:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_e k, input logic [127:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL ev_%s unexpected at cyc=%0d dat=%0h, required none", k.name(), edge_cnt, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != edge_cnt || e.dat != d) begin
        failures++;
        $display("FAIL ev_%s got kind=%s cyc=%0d dat=%0h, required kind=%s cyc=%0d dat=%0h",
                 e.kind.name(), k.name(), edge_cnt, d, e.kind.name(), e.cyc, e.dat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (flush)              check_ev(EV_FLUSH, '0);
      if (ckpt_miss)          check_ev(EV_MISS,  '0);
      if (walk_valid)         check_ev(EV_WALK,  128'(walk_tag));
      if (rdy_restore_valid)  check_ev(EV_RDY,   rdy_restore);
      if (tail_restore_valid) check_ev(EV_TAIL,  128'(tail_restore));
      if (redirect_valid)     check_ev(EV_REDIR, 128'(redirect_pc));
    end
  end

  function automatic logic [255:0] all_outs();
    return 256'({walk_valid, walk_tag, flush, stall_frontend, rdy_restore_valid, rdy_restore,
                 tail_restore_valid, tail_restore, redirect_valid, redirect_pc, busy, ckpt_miss});
  endfunction

  task automatic check_eq(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic drive_mp(input logic [4:0] tag, input logic [4:0] tail, input logic [31:0] tgt,
                          input logic cv, input logic [127:0] tbl);
    mispredict        = 1'b1;
    mispredict_tag    = tag;
    mispredict_target = tgt;
    rob_tail          = tail;
    checkpoint_valid  = cv;
    snapshot          = '{pc: 32'hCAFE_0000, rob_tag: tag, reg_rdy_table: tbl, valid: cv};
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(name, 256'(busy), 256'(0));
  endtask

  initial begin
    reset = 1'b1;
    mispredict = 1'b0;
    mispredict_tag = '0;
    mispredict_target = '0;
    rob_tail = '0;
    checkpoint_valid = 1'b0;
    snapshot = '0;
    walk_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outs(), '0);
    reset = 1'b0;
    @(negedge clk);

    // No walk: tag 5, tail 6.
    t = edge_cnt + 1;
    push_exp(EV_FLUSH, t, '0);
    push_exp(EV_RDY, t + 1, TBL_A);
    push_exp(EV_TAIL, t + 1, 128'd6);
    push_exp(EV_REDIR, t + 2, 128'h1000);
    drive_mp(5'd5, 5'd6, 32'h0000_1000, 1'b1, TBL_A);
    @(negedge clk) mispredict = 1'b0;
    wait_idle("idle_t1");

    // Four-entry walk: tag 3, tail 8.
    t = edge_cnt + 1;
    push_exp(EV_FLUSH, t, '0);
    push_exp(EV_WALK, t + 1, 128'd7);
    push_exp(EV_WALK, t + 2, 128'd6);
    push_exp(EV_WALK, t + 3, 128'd5);
    push_exp(EV_WALK, t + 4, 128'd4);
    push_exp(EV_RDY, t + 5, TBL_B);
    push_exp(EV_TAIL, t + 5, 128'd4);
    push_exp(EV_REDIR, t + 6, 128'h2000);
    drive_mp(5'd3, 5'd8, 32'h0000_2000, 1'b1, TBL_B);
    @(negedge clk) mispredict = 1'b0;
    wait_idle("idle_t2");

    // Wrap: tag 30, tail 2 walks 1, 0, 31.
    t = edge_cnt + 1;
    push_exp(EV_FLUSH, t, '0);
    push_exp(EV_WALK, t + 1, 128'd1);
    push_exp(EV_WALK, t + 2, 128'd0);
    push_exp(EV_WALK, t + 3, 128'd31);
    push_exp(EV_RDY, t + 4, TBL_C);
    push_exp(EV_TAIL, t + 4, 128'd31);
    push_exp(EV_REDIR, t + 5, 128'h8000_0040);
    drive_mp(5'd30, 5'd2, 32'h8000_0040, 1'b1, TBL_C);
    @(negedge clk) mispredict = 1'b0;
    wait_idle("idle_t3");

    // walk_ready low for three cycles on the first entry.
    t = edge_cnt + 1;
    push_exp(EV_FLUSH, t, '0);
    for (int i = 1; i <= 4; i++) push_exp(EV_WALK, t + i, 128'd5);
    push_exp(EV_WALK, t + 5, 128'd4);
    push_exp(EV_RDY, t + 6, TBL_D);
    push_exp(EV_TAIL, t + 6, 128'd4);
    push_exp(EV_REDIR, t + 7, 128'h3300);
    drive_mp(5'd3, 5'd6, 32'h0000_3300, 1'b1, TBL_D);
    walk_ready = 1'b0;
    @(negedge clk) mispredict = 1'b0;
    repeat (4) @(negedge clk);
    walk_ready = 1'b1;
    wait_idle("idle_t4");

    // Missing checkpoint: miss pulse, no ready-table restore.
    t = edge_cnt + 1;
    push_exp(EV_FLUSH, t, '0);
    push_exp(EV_MISS, t, '0);
    push_exp(EV_TAIL, t + 1, 128'd11);
    push_exp(EV_REDIR, t + 2, 128'h4000);
    drive_mp(5'd10, 5'd11, 32'h0000_4000, 1'b0, TBL_A);
    @(negedge clk) mispredict = 1'b0;
    wait_idle("idle_t5");

    // Second mispredict while walking is ignored.
    t = edge_cnt + 1;
    push_exp(EV_FLUSH, t, '0);
    push_exp(EV_WALK, t + 1, 128'd2);
    push_exp(EV_WALK, t + 2, 128'd1);
    push_exp(EV_RDY, t + 3, TBL_B);
    push_exp(EV_TAIL, t + 3, 128'd1);
    push_exp(EV_REDIR, t + 4, 128'h5000);
    drive_mp(5'd0, 5'd3, 32'h0000_5000, 1'b1, TBL_B);
    @(negedge clk) mispredict = 1'b0;
    @(negedge clk) drive_mp(5'd20, 5'd25, 32'h4444_0000, 1'b1, TBL_C);
    @(negedge clk) mispredict = 1'b0;
    wait_idle("idle_t6");

    // Mispredict held through recovery is taken again on the first IDLE edge.
    t = edge_cnt + 1;
    push_exp(EV_FLUSH, t, '0);
    push_exp(EV_RDY, t + 1, TBL_A);
    push_exp(EV_TAIL, t + 1, 128'd6);
    push_exp(EV_REDIR, t + 2, 128'h6000);
    push_exp(EV_FLUSH, t + 4, '0);
    push_exp(EV_WALK, t + 5, 128'd13);
    push_exp(EV_RDY, t + 6, TBL_D);
    push_exp(EV_TAIL, t + 6, 128'd13);
    push_exp(EV_REDIR, t + 7, 128'h7000);
    drive_mp(5'd5, 5'd6, 32'h0000_6000, 1'b1, TBL_A);
    @(negedge clk) drive_mp(5'd12, 5'd14, 32'h0000_7000, 1'b1, TBL_D);
    repeat (4) @(negedge clk);
    mispredict = 1'b0;
    wait_idle("idle_t7");

    // Reset mid-walk drops every output at once.
    t = edge_cnt + 1;
    push_exp(EV_FLUSH, t, '0);
    push_exp(EV_WALK, t + 1, 128'd19);
    push_exp(EV_WALK, t + 2, 128'd18);
    drive_mp(5'd0, 5'd20, 32'h0000_8000, 1'b1, TBL_C);
    @(negedge clk) mispredict = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_eq("reset_mid_walk", all_outs(), '0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    // Restart after reset; tail restore wraps 31 -> 0.
    t = edge_cnt + 1;
    push_exp(EV_FLUSH, t, '0);
    push_exp(EV_WALK, t + 1, 128'd0);
    push_exp(EV_RDY, t + 2, TBL_B);
    push_exp(EV_TAIL, t + 2, 128'd0);
    push_exp(EV_REDIR, t + 3, 128'h9000);
    drive_mp(5'd31, 5'd1, 32'h0000_9000, 1'b1, TBL_B);
    @(negedge clk) mispredict = 1'b0;
    wait_idle("idle_t9");

    repeat (3) @(negedge clk);
    check_eq("pending_events", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
